// File: rtl/mac_feeder_pkg.sv
// Shared types and helpers for the MAC operand feeder.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package mac_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    localparam int DEFAULT_DEPTH = 8;

    // Pointer width for a FIFO of 'depth' entries: one extra wrap bit so
    // that full and empty can be told apart when the indices match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; rd_data is always the current head entry.
// Latency: a push is visible on rd_data/empty the cycle after it is written.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
//
// Ports: clk, rst_n (async, active-low), wr_en/wr_data (push side),
//        rd_en/rd_data (pop side, head shown combinationally), full, empty.
module sync_fifo
    import mac_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;

    // Full when the indices match but the wrap bits differ.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A push against a full FIFO is lost even if a pop frees a slot this cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers A/B operands and sequences one clear + vec_len En-qualified pairs + done into a MAC.
// Latency: start->mac_clr 1 cycle, mac_clr->first mac_en >=2 cycles, last mac_en->done 1 cycle.
// Backpressure: RUN stalls while either FIFO is empty; writes to a full FIFO are dropped.
//
// Ports: clk, rst_n (async, active-low); a_wr_en/a_wr_data, b_wr_en/b_wr_data push
//        operands, a_full/b_full report FIFO state; start/vec_len launch an operation,
//        busy/done report progress; mac_en/mac_clr/mac_ain/mac_bin drive the MAC.
// Optional: define MAC_FEEDER_STATS_EN to add stall_cycles[15:0], a saturating count of
//           RUN cycles stalled on an empty FIFO, cleared when start is accepted.
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_wr_en,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic                  b_wr_en,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  a_full,
    output logic                  b_full,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    output logic                  busy,
    output logic                  done,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_ain,
    output logic [DATA_WIDTH-1:0] mac_bin
`ifdef MAC_FEEDER_STATS_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    feeder_state_t         state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  a_empty;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] a_head;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  pop;

    // Both FIFOs always pop together so the A/B pairing never skews.
    assign pop = (state == RUN) && !a_empty && !b_empty && (cnt < len_q);

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (a_wr_en),
        .wr_data (a_wr_data),
        .rd_en   (pop),
        .rd_data (a_head),
        .full    (a_full),
        .empty   (a_empty)
    );

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (b_wr_en),
        .wr_data (b_wr_data),
        .rd_en   (pop),
        .rd_data (b_head),
        .full    (b_full),
        .empty   (b_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            mac_ain <= '0;
            mac_bin <= '0;
        end else begin
            mac_en  <= pop;
            mac_clr <= 1'b0;
            done    <= 1'b0;
            // Operand registers hold their last value while mac_en is low.
            if (pop) begin
                mac_ain <= a_head;
                mac_bin <= b_head;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= vec_len;
                        cnt     <= '0;
                        mac_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (len_q == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Leaving one cycle after the last pop lets the final mac_en
                    // land before done, so the MAC has absorbed the last product.
                    if (cnt == len_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (pop) begin
                        cnt <= cnt + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MAC_FEEDER_STATS_EN
    // Only stalls caused by an empty FIFO count; the final RUN cycle where
    // cnt == len_q is not a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == RUN && (cnt < len_q) && (a_empty || b_empty)
                     && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;

    logic       clk;
    logic       rst_n;
    logic       a_wr_en;
    logic [7:0] a_wr_data;
    logic       b_wr_en;
    logic [7:0] b_wr_data;
    logic       a_full;
    logic       b_full;
    logic       start;
    logic [7:0] vec_len;
    logic       busy;
    logic       done;
    logic       mac_en;
    logic       mac_clr;
    logic [7:0] mac_ain;
    logic [7:0] mac_bin;
`ifdef MAC_FEEDER_STATS_EN
    logic [15:0] stall_cycles;
`endif

    mac_operand_feeder #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .LEN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_wr_en   (a_wr_en),
        .a_wr_data (a_wr_data),
        .b_wr_en   (b_wr_en),
        .b_wr_data (b_wr_data),
        .a_full    (a_full),
        .b_full    (b_full),
        .start     (start),
        .vec_len   (vec_len),
        .busy      (busy),
        .done      (done),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_ain   (mac_ain),
        .mac_bin   (mac_bin)
`ifdef MAC_FEEDER_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int clr_n, en_n, done_n, clr_cyc, done_cyc, acc;
    int en_q[$];
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    int bp[3];
    int s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then observe the outputs of the new cycle and feed
    // a simple reference MAC (clear on mac_clr, accumulate on mac_en).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mac_clr) begin
            clr_n++;
            clr_cyc = cyc;
            acc = 0;
        end
        if (mac_en) begin
            en_n++;
            en_q.push_back(cyc);
            pa.push_back(mac_ain);
            pb.push_back(mac_bin);
            acc += int'(mac_ain) * int'(mac_bin);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    endtask

    task automatic mon_clear();
        clr_n = 0; en_n = 0; done_n = 0; clr_cyc = -1; done_cyc = -1; acc = 0;
        en_q.delete(); pa.delete(); pb.delete();
    endtask

    task automatic push_ab(input logic wa, input logic [7:0] da, input logic wb, input logic [7:0] db);
        a_wr_en = wa; a_wr_data = da; b_wr_en = wb; b_wr_data = db;
        tick();
        a_wr_en = 1'b0; b_wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] len);
        s = cyc;
        start = 1'b1; vec_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        k = 0;
        while (done_n == 0 && k < max) begin
            tick();
            k++;
        end
        check(tag, 32'(done_n != 0), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; a_wr_en = 0; a_wr_data = 0; b_wr_en = 0; b_wr_data = 0;
        start = 0; vec_len = 0;
        mon_clear();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Preload, then reset: everything back to zero
        for (int i = 0; i < 8; i++) push_ab(1'b1, 8'(i + 1), 1'b1, 8'(i + 2));
        check("preload_a_full", 32'(a_full), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_a_full", 32'(a_full), 32'd0);
        check("rst_b_full", 32'(b_full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'(mac_en), 32'd0);
        check("rst_clr", 32'(mac_clr), 32'd0);
        check("rst_ain", 32'(mac_ain), 32'd0);
        check("rst_bin", 32'(mac_bin), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic dot product (1,4),(2,5),(3,6) = 32
        mon_clear();
        for (int i = 0; i < 3; i++) push_ab(1'b1, 8'(i + 1), 1'b1, 8'(i + 4));
        do_start(8'd3);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done_seen", 20);
        tick(); tick();
        check("t1_clr_n", 32'(clr_n), 32'd1);
        check("t1_clr_cyc", 32'(clr_cyc), 32'(s + 1));
        check("t1_en_n", 32'(en_n), 32'd3);
        if (en_n == 3) begin
            check("t1_en0_cyc", 32'(en_q[0]), 32'(s + 3));
            check("t1_en2_cyc", 32'(en_q[2]), 32'(s + 5));
            check("t1_pair0", {pa[0], pb[0]}, {8'd1, 8'd4});
            check("t1_pair1", {pa[1], pb[1]}, {8'd2, 8'd5});
            check("t1_pair2", {pa[2], pb[2]}, {8'd3, 8'd6});
        end
        check("t1_done_cyc", 32'(done_cyc), 32'(s + 6));
        check("t1_done_n", 32'(done_n), 32'd1);
        check("t1_acc", 32'(acc), 32'd32);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_hold_ain", 32'(mac_ain), 32'd3);

        // Stalling on B: one B element every 3 cycles
        mon_clear();
        for (int i = 0; i < 3; i++) push_ab(1'b1, 8'(i + 1), 1'b0, 8'd0);
        do_start(8'd3);
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
            bp[i] = cyc;
            push_ab(1'b0, 8'd0, 1'b1, 8'(i + 4));
        end
        wait_done("t2_done_seen", 20);
        check("t2_en_n", 32'(en_n), 32'd3);
        if (en_n == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t2_en_cyc", 32'(en_q[i]), 32'(bp[i] + 2));
                check("t2_pair", {pa[i], pb[i]}, {8'(i + 1), 8'(i + 4)});
            end
            check("t2_done_after_last_en", 32'(done_cyc), 32'(en_q[2] + 1));
        end
        check("t2_acc", 32'(acc), 32'd32);
`ifdef MAC_FEEDER_STATS_EN
        check("t2_stall_cycles", 32'(stall_cycles), 32'd6);
`endif
        tick();

        // Overflow: 9 writes into an 8-deep A FIFO, 9th dropped
        mon_clear();
        for (int i = 0; i < 9; i++) begin
            push_ab(1'b1, 8'(10 + i), 1'b0, 8'd0);
            if (i == 6) check("t3_not_full_7", 32'(a_full), 32'd0);
            if (i == 7) check("t3_full_8", 32'(a_full), 32'd1);
        end
        for (int i = 0; i < 8; i++) push_ab(1'b0, 8'd0, 1'b1, 8'd1);
        check("t3_b_full", 32'(b_full), 32'd1);
        do_start(8'd8);
        wait_done("t3_done_seen", 30);
        check("t3_en_n", 32'(en_n), 32'd8);
        if (en_n == 8) check("t3_last_a", 32'(pa[7]), 32'd17);
        check("t3_acc", 32'(acc), 32'd108);
        tick();
        check("t3_a_drained", 32'(a_full), 32'd0);
        mon_clear();
        push_ab(1'b1, 8'd77, 1'b1, 8'd3);
        do_start(8'd1);
        wait_done("t3b_done_seen", 20);
        check("t3b_en_n", 32'(en_n), 32'd1);
        if (en_n == 1) check("t3b_ain_not_9th", 32'(pa[0]), 32'd77);
        check("t3b_acc", 32'(acc), 32'd231);
        tick();

        // vec_len = 0, plus start while busy ignored
        mon_clear();
        do_start(8'd0);
        check("t4_clr", 32'(mac_clr), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        start = 1'b1; vec_len = 8'd5;
        tick();
        start = 1'b0;
        check("t4_done_at_2", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t4_no_en", 32'(en_n), 32'd0);
        check("t4_done_n", 32'(done_n), 32'd1);
        check("t4_clr_n", 32'(clr_n), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);

        // Reset during RUN after 2 of 5 pairs
        mon_clear();
        for (int i = 0; i < 5; i++) push_ab(1'b1, 8'(i + 1), i < 2, 8'd2);
        do_start(8'd5);
        for (int k = 0; k < 20 && en_n < 2; k++) tick();
        tick(); tick();
        check("t5_two_pairs", 32'(en_n), 32'd2);
        check("t5_busy_stalled", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_en", 32'(mac_en), 32'd0);
        check("t5_rst_ain", 32'(mac_ain), 32'd0);
        tick(); tick();
        #2;
        rst_n = 1'b1;
        tick(); tick();
        check("t5_no_done", 32'(done_n), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        mon_clear();
        push_ab(1'b1, 8'd9, 1'b1, 8'd9);
        do_start(8'd1);
        wait_done("t5b_done_seen", 20);
        check("t5b_en_n", 32'(en_n), 32'd1);
        if (en_n == 1) check("t5b_fifo_flushed", 32'(pa[0]), 32'd9);
        check("t5b_acc", 32'(acc), 32'd81);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
